// File: rtl/e203_itcm_sram_ctrl_pkg.sv
// Shared types and helpers for the ITCM SRAM controller.
package e203_itcm_sram_ctrl_pkg;

    typedef enum logic {
        LS_AWAKE = 1'b0,
        LS_SLEEP = 1'b1
    } ls_state_e;

    localparam int unsigned RSP_BUF_DEPTH = 2;

    // Width needed to hold 0..n; a zero limit still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/e203_itcm_rsp_buf.sv
// Two-entry response FIFO; the head is always presented, bypass lives in the parent.
module e203_itcm_rsp_buf
    import e203_itcm_sram_ctrl_pkg::*;
#(
    parameter int unsigned RAM_DW = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [RAM_DW-1:0] din,
    output logic [RAM_DW-1:0] head,
    output logic [1:0]        cnt
);

    logic [RAM_DW-1:0] mem [RSP_BUF_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/e203_itcm_sram_ctrl.sv
// ITCM SRAM initiator: ICB-style cmd/rsp to SRAM port, 2-deep response
// buffering against back-pressure, and idle-driven light sleep.
module e203_itcm_sram_ctrl
    import e203_itcm_sram_ctrl_pkg::*;
#(
    parameter  int unsigned RAM_AW      = 13,
    parameter  int unsigned RAM_DW      = 64,
    parameter  int unsigned RAM_MW      = 8,
    parameter  int unsigned LS_IDLE_CYC = 16,
    localparam int unsigned BYTE_OFS    = $clog2(RAM_MW)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_read,
    input  logic [RAM_AW+BYTE_OFS-1:0] cmd_addr,
    input  logic [RAM_DW-1:0]          cmd_wdata,
    input  logic [RAM_MW-1:0]          cmd_wmask,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [RAM_DW-1:0]          rsp_rdata,
    output logic                       ram_cs,
    output logic                       ram_we,
    output logic [RAM_AW-1:0]          ram_addr,
    output logic [RAM_MW-1:0]          ram_wem,
    output logic [RAM_DW-1:0]          ram_din,
    input  logic [RAM_DW-1:0]          ram_dout,
    output logic                       ram_ls,
    output logic                       ram_sd,
    output logic                       ram_ds
);

    localparam int unsigned IDLE_W = cnt_width(LS_IDLE_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(LS_IDLE_CYC);

    logic              fire;
    logic              inflight;
    logic              rd_q;
    logic [1:0]        cnt;
    logic [2:0]        occupancy;
    logic [RAM_DW-1:0] rsp_word;
    logic [RAM_DW-1:0] buf_head;
    logic              buf_push;
    logic              buf_pop;
    logic              buf_empty;
    ls_state_e         ls_state;
    logic [IDLE_W-1:0] idle_cnt;
    logic              unused_addr_lsb;

    // Credit: buffered + in-flight responses never exceed the buffer depth.
    assign occupancy = {1'b0, cnt} + {2'b00, inflight};
    assign cmd_ready = ~ram_ls & (occupancy < 3'(RSP_BUF_DEPTH));
    assign fire      = cmd_valid & cmd_ready;

    assign ram_cs   = fire;
    assign ram_we   = fire & ~cmd_read;
    assign ram_addr = cmd_addr[RAM_AW+BYTE_OFS-1:BYTE_OFS];
    assign ram_wem  = (fire & ~cmd_read) ? cmd_wmask : '0;
    assign ram_din  = cmd_wdata;
    assign ram_sd   = 1'b0;
    assign ram_ds   = 1'b0;

    assign unused_addr_lsb = ^cmd_addr[BYTE_OFS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            inflight <= fire;
            rd_q     <= fire & cmd_read;
        end
    end

    // Write responses carry zero data; nothing in flight also reads as zero.
    assign rsp_word  = (inflight & rd_q) ? ram_dout : '0;
    assign buf_empty = (cnt == 2'd0);

    assign rsp_valid = buf_empty ? inflight : 1'b1;
    assign rsp_rdata = buf_empty ? rsp_word : buf_head;
    assign buf_push  = inflight & (~buf_empty | ~rsp_ready);
    assign buf_pop   = ~buf_empty & rsp_ready;

    e203_itcm_rsp_buf #(
        .RAM_DW (RAM_DW)
    ) u_rsp_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (buf_push),
        .pop   (buf_pop),
        .din   (rsp_word),
        .head  (buf_head),
        .cnt   (cnt)
    );

    // Light-sleep FSM; a zero limit keeps the counter pinned and never sleeps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ls_state <= LS_AWAKE;
            idle_cnt <= '0;
            ram_ls   <= 1'b0;
        end else begin
            case (ls_state)
                LS_AWAKE: begin
                    if (fire) begin
                        idle_cnt <= '0;
                    end else if ((LS_IDLE_CYC != 0) && (idle_cnt == IDLE_LIM)) begin
                        ls_state <= LS_SLEEP;
                        ram_ls   <= 1'b1;
                        idle_cnt <= '0;
                    end else if (buf_empty && (idle_cnt != IDLE_LIM)) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                LS_SLEEP: begin
                    if (cmd_valid) begin
                        ls_state <= LS_AWAKE;
                        ram_ls   <= 1'b0;
                        idle_cnt <= '0;
                    end
                end
                default: begin
                    ls_state <= LS_AWAKE;
                    ram_ls   <= 1'b0;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/e203_itcm_sram_ctrl.md
# e203_itcm_sram_ctrl

Initiator-side controller for the ITCM SRAM macro wrapper. It accepts ICB-style read/write commands from the core/bus side and drives the SRAM port (`cs`/`we`/`addr`/`wem`/`din`, plus `sd`/`ds`/`ls`). It captures the SRAM's 1-cycle-latency `dout` into a 2-entry response buffer so that back-pressure on the response channel never loses data. It also puts the SRAM into light sleep after a programmable idle period. It sits between the ITCM bus arbiter and the ITCM RAM wrapper.

## Interface
Parameters:
- `RAM_AW`, default 13: SRAM word-address width.
- `RAM_DW`, default 64: SRAM data width.
- `RAM_MW`, default 8: byte-mask width, equal to `RAM_DW`/8.
- `LS_IDLE_CYC`, default 16: number of idle cycles before `ram_ls` is asserted. A value of 0 disables light sleep.

Ports (all widths are in bits):
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: command request.
- `cmd_ready`, output, 1: command accepted when high together with `cmd_valid`.
- `cmd_read`, input, 1: 1 = read, 0 = write.
- `cmd_addr`, input, `RAM_AW`+log2(`RAM_MW`): byte address. The low log2(`RAM_MW`) bits are ignored.
- `cmd_wdata`, input, `RAM_DW`: write data.
- `cmd_wmask`, input, `RAM_MW`: byte-enable mask for writes.
- `rsp_valid`, output, 1: response available.
- `rsp_ready`, input, 1: response consumed when high together with `rsp_valid`.
- `rsp_rdata`, output, `RAM_DW`: read data. It is 0 for write responses.
- `ram_cs`, output, 1: SRAM chip select.
- `ram_we`, output, 1: SRAM write enable.
- `ram_addr`, output, `RAM_AW`: SRAM word address, equal to `cmd_addr[MSB:log2(RAM_MW)]`.
- `ram_wem`, output, `RAM_MW`: SRAM byte write mask.
- `ram_din`, output, `RAM_DW`: SRAM write data.
- `ram_dout`, input, `RAM_DW`: SRAM read data, valid one cycle after a read select.
- `ram_ls`, output, 1: SRAM light-sleep request.
- `ram_sd`, output, 1: SRAM shutdown. Constant 0.
- `ram_ds`, output, 1: SRAM deep sleep. Constant 0.

## Operation
- **Command acceptance.** A command is accepted on the cycle where `cmd_valid & cmd_ready` is high (the fire cycle).
  - In the fire cycle the SRAM signals are driven combinationally: `ram_cs`=1, `ram_we`=~`cmd_read`, `ram_addr`, `ram_wem`=`cmd_wmask` (forced to 0 on reads), `ram_din`=`cmd_wdata`.
  - When no command fires, `ram_cs`=0 and `ram_we`=0.
- **Credit rule.**
  - `inflight` is a 1-bit register, set in the fire cycle and cleared on the following cycle unless a new command fires.
  - `cnt` is the response-buffer occupancy, 0..2.
  - `cmd_ready` = ~`ram_ls` & (`cnt` + `inflight` < 2). `cmd_ready` never depends combinationally on `rsp_ready`.
- **Response path.**
  - In the cycle after a fire, the response word is `ram_dout` for a read, or 0 for a write.
  - If the buffer is empty, the response word is bypassed directly to `rsp_*`. If it is not taken that cycle, it is written into the buffer.
  - If the buffer is non-empty, the response word is pushed into the buffer and `rsp_*` presents the buffer head.
  - Responses are delivered in command order. One response is produced per command, for both reads and writes.
- **Light-sleep state machine.** States: AWAKE, SLEEP.
  - AWAKE: the idle counter increments on cycles with no fire and `cnt`==0, and clears on any fire.
  - AWAKE → SLEEP when the idle counter reaches `LS_IDLE_CYC` (only if `LS_IDLE_CYC` ≠ 0). `ram_ls` is registered and is 1 in SLEEP.
  - SLEEP → AWAKE on the clock edge after `cmd_valid` is sampled high. `cmd_ready`=0 for that wake cycle, and the idle counter clears.
- **Reset values:**
  - `cmd_ready`=1
  - `rsp_valid`=0
  - `rsp_rdata`=0
  - `ram_cs`=0
  - `ram_we`=0
  - `ram_ls`=0
  - `inflight`=0
  - `cnt`=0
  - idle counter = 0

## Timing
- Read latency with `rsp_ready`=1: the response appears in cycle N+1 for a fire in cycle N.
- Throughput is 1 command per cycle sustained while `rsp_ready`=1.
- With `rsp_ready`=0:
  - at most 2 responses are buffered;
  - `cmd_ready` falls once `cnt` + `inflight` reaches 2;
  - no response is ever dropped or overwritten.
- Simultaneous push and pop on a buffer with `cnt`==2 is impossible by the credit rule. With `cnt`==1, a simultaneous push and pop keeps `cnt`=1.
- Wake from SLEEP costs exactly 1 cycle: the command is presented in cycle N, `ram_ls`=0 in N+1, and the command fires in N+1.
- An asynchronous reset mid-operation immediately drops `ram_cs`, `rsp_valid` and `ram_ls`. Buffered responses are discarded. The upstream side must be reset concurrently.

## Structure
- The SRAM width, depth and mask constants come from the shared `e203_defines.v` macros (`E203_ITCM_RAM_AW`, `E203_ITCM_RAM_DW`, `E203_ITCM_RAM_MW`). Instantiators pass these macros as the parameters.
- Add `E203_ITCM_LS_IDLE_CYC` to `e203_defines.v`.
- One sub-module, `e203_itcm_rsp_buf`: a 2-entry, `RAM_DW`-wide FIFO with push/pop/`cnt`, asynchronous active-low reset, head output, and no bypass. The bypass mux lives in the top level.

## Test plan
- Back-to-back reads with `rsp_ready`=1: write 0x1122334455667788 to word 0x10, then 4 consecutive reads of 0x10–0x13. Each `rsp_rdata` appears 1 cycle after its fire, and `cmd_ready` stays 1.
- Partial write: `cmd_wmask`=0x0F with `cmd_wdata`=0xFFFF_FFFF_FFFF_FFFF to a word holding 0x1122334455667788. A subsequent read returns 0x11223344FFFFFFFF, and the write response carries `rsp_rdata`=0.
- Back-pressure: hold `rsp_ready`=0 and issue 3 reads. Only 2 fire, and `cmd_ready`=0 after the second. Release `rsp_ready`: the 3 responses drain in order with correct data.
- Light sleep: with `LS_IDLE_CYC`=16 and idle from reset, `ram_ls`=1 on cycle 17. Assert `cmd_valid`: `cmd_ready`=0 for 1 cycle, then the read fires and `ram_ls`=0.
- Reset mid-operation: assert `rst_n`=0 with 2 responses buffered. `rsp_valid`, `ram_cs` and `ram_ls` go to 0 asynchronously. After release, `cmd_ready`=1 and no stale response appears.
